down_timer32: RTL
=================

DOWN_TIMER32 -- requirements
Module: down_timer32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the counter and load width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port load_val, input, WIDTH, the start/reload value, sampled only on an accepted start.
REQ-005 The block SHALL have port periodic, input, 1, the auto-reload mode select, sampled only on an accepted start.
REQ-006 The block SHALL have port start, input, 1, a single-cycle request to (re)load and run.
REQ-007 The block SHALL have port stop, input, 1, a single-cycle request to abort the run.
REQ-008 The block SHALL have port en, input, 1, the tick enable; while low, cnt holds.
REQ-009 The block SHALL have port cnt, output, WIDTH, the remaining ticks.
REQ-010 The block SHALL have port busy, output, 1, high while in RUN.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse at expiry.

Function
REQ-012 The FSM SHALL have two states: IDLE and RUN; all outputs SHALL be registered.
REQ-013 Input priority each cycle SHALL be: stop > start > en tick.
REQ-014 IDLE with start=1, stop=0, load_val!=0: the block SHALL latch load_val into reload_reg, latch periodic into mode_reg, set cnt<=load_val, and go to RUN (busy=1 next cycle).
REQ-015 IDLE with start=1, load_val==0: the block SHALL pulse done next cycle, keep cnt=0, and stay in IDLE, regardless of periodic.
REQ-016 RUN with en=1 and cnt>1: the block SHALL set cnt<=cnt-1.
REQ-017 RUN with en=1, cnt==1, mode_reg=0: the block SHALL set cnt<=0 and done<=1, and go to IDLE (busy=0 in the same cycle done=1).
REQ-018 RUN with en=1, cnt==1, mode_reg=1: the block SHALL set cnt<=reload_reg and done<=1, and stay in RUN; the period SHALL be reload_reg enabled ticks.
REQ-019 RUN with en=0: cnt SHALL hold and done SHALL stay 0.
REQ-020 RUN with stop=1: the block SHALL go to IDLE, hold cnt at its current value, and not pulse done.
REQ-021 RUN with start=1 (stop=0): the block SHALL restart per REQ-014/015 with new values; no done pulse from the abandoned run.
REQ-022 stop in IDLE SHALL have no effect; start with stop in IDLE SHALL be ignored.
REQ-023 done SHALL be high for exactly one cycle per expiry and SHALL never be high two consecutive cycles unless reload_reg==1 in periodic mode.
REQ-024 Arithmetic SHALL be unsigned WIDTH-bit; cnt SHALL never wrap below 0.

Reset
REQ-025 On rst_n low (asynchronous), the block SHALL set state=IDLE and cnt, busy, done, reload_reg, mode_reg (and exp_cnt if present) all to 0.
REQ-026 Reset mid-run SHALL abort without a done pulse; the first start after rst_n deasserts SHALL behave as REQ-014.

Configuration
REQ-027 When macro DOWN_TIMER32_EXP_CNT_EN is defined, the block SHALL add output exp_cnt [15:0], incremented on every done pulse and wrapping 0xFFFF->0x0000; it is cleared only by reset.
REQ-028 When DOWN_TIMER32_EXP_CNT_EN is undefined, exp_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 A shared package down_timer_pkg SHALL hold the state enum (IDLE, RUN) and the default width constant TIMER_WIDTH=32.
REQ-030 No sub-module is natural; the FSM, counter and optional exp_cnt SHALL be in down_timer32.

Verification
REQ-031 start with load_val=5, periodic=0, en=1 held -> cnt 5,4,3,2,1,0; done pulses once 5 cycles after start; busy falls with done.
REQ-032 start with load_val=3, periodic=1, en=1 -> done every 3 cycles, cnt 3,2,1,3,2,1...; stop -> busy=0, no further done.
REQ-033 start with load_val=4, en toggling 1,0,1,0... -> done after 4 enabled ticks (8 cycles); cnt holds on en=0 cycles.
REQ-034 start with load_val=0 -> done pulse next cycle, busy stays 0; stop and start together in IDLE -> ignored.
REQ-035 run with load_val=10; at cnt=6 assert start with load_val=2 -> cnt 2,1,0, one done; at cnt=6 assert rst_n=0 instead -> all outputs 0 immediately, no done.
REQ-036 With DOWN_TIMER32_EXP_CNT_EN defined: periodic run with load_val=1 for 65537 cycles -> exp_cnt wraps to 0x0001.

Source files
------------

// File: rtl/down_timer32_pkg.sv
// Shared types and constants for the down_timer32 block.
package down_timer_pkg;

  localparam int TIMER_WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/down_timer32_if.sv
// Control/status bundle between a timer user (master) and down_timer32 (slave).
// exp_cnt is present only when DOWN_TIMER32_EXP_CNT_EN is defined.
interface down_timer32_if
  import down_timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) ();

  logic [WIDTH-1:0] load_val;
  logic             periodic;
  logic             start;
  logic             stop;
  logic             en;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;
`ifdef DOWN_TIMER32_EXP_CNT_EN
  logic [15:0]      exp_cnt;

  modport master (output load_val, periodic, start, stop, en,
                  input  cnt, busy, done, exp_cnt);
  modport slave  (input  load_val, periodic, start, stop, en,
                  output cnt, busy, done, exp_cnt);
`else
  modport master (output load_val, periodic, start, stop, en,
                  input  cnt, busy, done);
  modport slave  (input  load_val, periodic, start, stop, en,
                  output cnt, busy, done);
`endif

endinterface

// File: rtl/down_timer32.sv
// One-shot / auto-reload down counter; all outputs registered, one cycle after the qualifying input.
// Optional 16-bit expiry counter enabled by DOWN_TIMER32_EXP_CNT_EN.
module down_timer32
  import down_timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  down_timer32_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;

  // Priority is stop > start > tick; stop while idle also swallows a start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    if (bus.stop) begin
      if (state_q == RUN) state_d = IDLE;
    end else if (bus.start) begin
      if (bus.load_val != '0) begin
        reload_d = bus.load_val;
        mode_d   = bus.periodic;
        cnt_d    = bus.load_val;
        state_d  = RUN;
      end else begin
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end else if (state_q == RUN && bus.en) begin
      if (cnt_q > WIDTH'(1)) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        done_d = 1'b1;
        if (mode_q) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;

`ifdef DOWN_TIMER32_EXP_CNT_EN
  logic [15:0] exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
    end else if (done_d) begin
      exp_q <= exp_q + 16'd1;
    end
  end

  assign bus.exp_cnt = exp_q;
`endif

endmodule
